// File: rtl/pipeline_stage3_ex.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stage3_ex
//  Purpose  : MIPS execute stage. Selects ALU operands, computes result, zero
//             flag, branch target and destination register, and loads them
//             with the MEM/WB control bits into the EX/MEM register. MUL runs
//             on an iterative shift-add unit that stalls upstream meanwhile.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_stage3_ex #(
  parameter int N = 32,
  localparam int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic          flush,
  input  logic [N-1:0]  pc_plus1,
  input  logic [N-1:0]  read_data1,
  input  logic [N-1:0]  read_data2,
  input  logic [N-1:0]  imm,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  input  logic          reg_dst,
  input  logic          alu_src,
  input  logic [3:0]    alu_ctrl,
  input  logic          branch,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          mem_to_reg,
  input  logic          reg_write,
  output logic          stall,
  output logic [N-1:0]  branch_addr_ex,
  output logic          zero_ex,
  output logic [N-1:0]  alu_out_ex,
  output logic [N-1:0]  write_data_ex,
  output logic [RW-1:0] write_reg_ex,
  output logic          branch_ex,
  output logic          mem_read_ex,
  output logic          mem_write_ex,
  output logic          mem_to_reg_ex,
  output logic          reg_write_ex
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  localparam logic [RW-1:0] LAST_ITER = RW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [N-1:0]  operand_b;
  logic [RW-1:0] dest_reg;
  logic [N-1:0]  alu_result;
  logic [N-1:0]  result_value;
  logic          is_mul;
  logic          accept_mul;
  logic          load_result;

  // multiplier working registers
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [N-1:0]  acc;
  logic [RW-1:0] count;

  assign operand_b = alu_src ? imm : read_data2;
  assign dest_reg  = reg_dst ? rd : rt;
  assign is_mul    = (alu_ctrl == ALU_MUL);

  // A MUL is only taken from IDLE; a flush in the same cycle kills it instead.
  assign accept_mul = (state == IDLE) && valid_in && is_mul && !flush;

  // Stall is deliberately masked by reset so upstream never freezes on it.
  assign stall = !reset && (accept_mul || (state == MUL));

  // Single-cycle ALU; MUL is never routed through here (handled by acc).
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND: alu_result = read_data1 & operand_b;
      ALU_OR:  alu_result = read_data1 | operand_b;
      ALU_ADD: alu_result = read_data1 + operand_b;
      ALU_SUB: alu_result = read_data1 - operand_b;
      ALU_SLT: alu_result = {{(N-1){1'b0}},
                             ($signed(read_data1) < $signed(operand_b))};
      ALU_NOR: alu_result = ~(read_data1 | operand_b);
      default: alu_result = '0;
    endcase
  end

  // Next-state logic and the EX/MEM load decision; flush overrides all.
  always_comb begin
    state_next   = state;
    load_result  = 1'b0;
    result_value = alu_result;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && is_mul) begin
            state_next = MUL;
          end else if (valid_in) begin
            load_result = 1'b1;
          end
        end
        MUL: begin
          if (count == LAST_ITER) begin
            state_next = DONE;
          end
        end
        DONE: begin
          load_result  = 1'b1;
          result_value = acc;
          state_next   = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift-add multiplier: one multiplier bit per cycle, always N iterations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (accept_mul) begin
      mcand  <= read_data1;
      mplier <= operand_b;
      acc    <= '0;
      count  <= '0;
    end else if (state == MUL) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  // EX/MEM pipeline register; bubbles clear controls and leave data as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_addr_ex <= '0;
      zero_ex        <= 1'b0;
      alu_out_ex     <= '0;
      write_data_ex  <= '0;
      write_reg_ex   <= '0;
      branch_ex      <= 1'b0;
      mem_read_ex    <= 1'b0;
      mem_write_ex   <= 1'b0;
      mem_to_reg_ex  <= 1'b0;
      reg_write_ex   <= 1'b0;
    end else if (load_result) begin
      branch_addr_ex <= pc_plus1 + imm;
      zero_ex        <= (result_value == '0);
      alu_out_ex     <= result_value;
      write_data_ex  <= read_data2;
      write_reg_ex   <= dest_reg;
      branch_ex      <= branch;
      mem_read_ex    <= mem_read;
      mem_write_ex   <= mem_write;
      mem_to_reg_ex  <= mem_to_reg;
      reg_write_ex   <= reg_write;
    end else begin
      branch_ex      <= 1'b0;
      mem_read_ex    <= 1'b0;
      mem_write_ex   <= 1'b0;
      mem_to_reg_ex  <= 1'b0;
      reg_write_ex   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage3_ex.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_stage3_ex
//  Purpose  : Self-checking bench for the execute stage: table of single-cycle
//             ALU vectors plus hand-written MUL, flush and reset sequences,
//             with a queue of expected EX/MEM contents per clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_stage3_ex;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        flush;
  logic [31:0] pc_plus1;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] imm;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        reg_dst;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic        branch;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        stall;
  logic [31:0] branch_addr_ex;
  logic        zero_ex;
  logic [31:0] alu_out_ex;
  logic [31:0] write_data_ex;
  logic [4:0]  write_reg_ex;
  logic        branch_ex;
  logic        mem_read_ex;
  logic        mem_write_ex;
  logic        mem_to_reg_ex;
  logic        reg_write_ex;
  logic [4:0]  ctl_out;

  assign ctl_out = {branch_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex, reg_write_ex};

  pipeline_stage3_ex #(.N(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .flush          (flush),
    .pc_plus1       (pc_plus1),
    .read_data1     (read_data1),
    .read_data2     (read_data2),
    .imm            (imm),
    .rt             (rt),
    .rd             (rd),
    .reg_dst        (reg_dst),
    .alu_src        (alu_src),
    .alu_ctrl       (alu_ctrl),
    .branch         (branch),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_to_reg     (mem_to_reg),
    .reg_write      (reg_write),
    .stall          (stall),
    .branch_addr_ex (branch_addr_ex),
    .zero_ex        (zero_ex),
    .alu_out_ex     (alu_out_ex),
    .write_data_ex  (write_data_ex),
    .write_reg_ex   (write_reg_ex),
    .branch_ex      (branch_ex),
    .mem_read_ex    (mem_read_ex),
    .mem_write_ex   (mem_write_ex),
    .mem_to_reg_ex  (mem_to_reg_ex),
    .reg_write_ex   (reg_write_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected EX/MEM contents after one clock edge.
  typedef struct {
    int          id;
    logic        bubble;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] baddr;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic [4:0]  ctl;
  } exp_t;

  // One single-cycle instruction plus its expected result fields.
  typedef struct {
    logic        valid;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_dst;
    logic        alu_src;
    logic [4:0]  ctl;
    logic [31:0] e_alu;
    logic [31:0] e_baddr;
    logic [4:0]  e_wreg;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  exp_t sb [$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s (item %0d): got %h expected %h at %0t", name, id, act, expv, $time);
    end
  endtask

  function automatic exp_t mk_bub(input int id);
    exp_t e;
    e.id = id; e.bubble = 1'b1; e.alu = '0; e.zero = 1'b0;
    e.baddr = '0; e.wdata = '0; e.wreg = '0; e.ctl = '0;
    return e;
  endfunction

  function automatic exp_t mk_res(input int id, input logic [31:0] alu, input logic [31:0] baddr,
                                  input logic [31:0] wdata, input logic [4:0] wreg, input logic [4:0] ctl);
    exp_t e;
    e.id = id; e.bubble = 1'b0; e.alu = alu; e.zero = (alu == 32'h0);
    e.baddr = baddr; e.wdata = wdata; e.wreg = wreg; e.ctl = ctl;
    return e;
  endfunction

  // Scoreboard consumer: compare EX/MEM just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      if (got.bubble) begin
        chk("bubble_ctl", got.id, {27'd0, ctl_out}, {27'd0, got.ctl});
      end else begin
        chk("alu_out_ex", got.id, alu_out_ex, got.alu);
        chk("zero_ex", got.id, {31'd0, zero_ex}, {31'd0, got.zero});
        chk("branch_addr_ex", got.id, branch_addr_ex, got.baddr);
        chk("write_data_ex", got.id, write_data_ex, got.wdata);
        chk("write_reg_ex", got.id, {27'd0, write_reg_ex}, {27'd0, got.wreg});
        chk("ctl_ex", got.id, {27'd0, ctl_out}, {27'd0, got.ctl});
      end
    end
  end

  task automatic drive(input logic v, input logic f, input logic [3:0] op, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] t, input logic [4:0] d, input logic rdst,
                       input logic asrc, input logic [4:0] ctl);
    valid_in = v; flush = f; alu_ctrl = op; pc_plus1 = pc;
    read_data1 = a; read_data2 = b; imm = im; rt = t; rd = d;
    reg_dst = rdst; alu_src = asrc;
    {branch, mem_read, mem_write, mem_to_reg, reg_write} = ctl;
  endtask

  // Called at a falling edge with inputs already applied: check stall,
  // queue the expectation for the coming edge, move to the next falling edge.
  task automatic cycle(input exp_t e, input logic exp_stall);
    #1;
    chk("stall", e.id, {31'd0, stall}, {31'd0, exp_stall});
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_mul(input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, 1'b0, OP_MUL, 32'h40, a, b, 32'h2, 5'd3, 5'd12, 1'b1, 1'b0, 5'b00001);
  endtask

  // MUL: 1 accept + 32 iteration cycles of bubbles/stall, then DONE result.
  // flush_at >= 0 flushes during that iteration and abandons the product.
  task automatic mul_seq(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int flush_at);
    set_mul(a, b);
    cycle(mk_bub(id), 1'b1);
    for (int k = 0; k < 32; k++) begin
      if (k == flush_at) begin
        flush = 1'b1;
        cycle(mk_bub(id), 1'b1);
        flush = 1'b0;
        valid_in = 1'b0;
        cycle(mk_bub(id), 1'b0);
        return;
      end
      cycle(mk_bub(id), 1'b1);
    end
    cycle(mk_res(id, expv, 32'h42, b, 5'd12, 5'b00001), 1'b0);
  endtask

  task automatic check_all_zero(input int id);
    chk("rst_alu_out_ex", id, alu_out_ex, 32'h0);
    chk("rst_zero_ex", id, {31'd0, zero_ex}, 32'h0);
    chk("rst_branch_addr_ex", id, branch_addr_ex, 32'h0);
    chk("rst_write_data_ex", id, write_data_ex, 32'h0);
    chk("rst_write_reg_ex", id, {27'd0, write_reg_ex}, 32'h0);
    chk("rst_ctl_ex", id, {27'd0, ctl_out}, 32'h0);
    chk("rst_stall", id, {31'd0, stall}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //          v     f     op      pc            a             b             imm           rt     rd     rdst  asrc  ctl       e_alu         e_baddr       e_wreg
    vt[0]  = '{1'b1, 1'b0, OP_SUB, 32'h10,       32'h7,        32'h7,        32'hFFFFFFFC, 5'd5,  5'd9,  1'b0, 1'b0, 5'b10000, 32'h0,        32'h0C,       5'd5};
    vt[1]  = '{1'b1, 1'b0, OP_SLT, 32'h20,       32'hFFFFFFFF, 32'h55,       32'h1,        5'd3,  5'd7,  1'b1, 1'b1, 5'b00001, 32'h1,        32'h21,       5'd7};
    vt[2]  = '{1'b1, 1'b0, OP_SLT, 32'h30,       32'hFFFFFFFF, 32'h1,        32'h0,        5'd2,  5'd9,  1'b0, 1'b0, 5'b00001, 32'h1,        32'h30,       5'd2};
    vt[3]  = '{1'b1, 1'b0, OP_SLT, 32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,        5'd4,  5'd31, 1'b1, 1'b0, 5'b00001, 32'h0,        32'h0,        5'd31};
    vt[4]  = '{1'b1, 1'b0, OP_ADD, 32'h100,      32'h7FFFFFFF, 32'h1,        32'h4,        5'd1,  5'd6,  1'b0, 1'b0, 5'b00001, 32'h80000000, 32'h104,      5'd1};
    vt[5]  = '{1'b1, 1'b0, OP_ADD, 32'h5,        32'hFFFFFFFF, 32'hAB,       32'h1,        5'd9,  5'd4,  1'b1, 1'b1, 5'b01011, 32'h0,        32'h6,        5'd4};
    vt[6]  = '{1'b1, 1'b0, OP_AND, 32'h0,        32'hF0F01234, 32'h0FF0FF00, 32'h10,       5'd6,  5'd1,  1'b0, 1'b0, 5'b00001, 32'h00F01200, 32'h10,       5'd6};
    vt[7]  = '{1'b1, 1'b0, OP_OR,  32'h1,        32'hF0,       32'h12,       32'hF,        5'd3,  5'd8,  1'b1, 1'b1, 5'b00001, 32'hFF,       32'h10,       5'd8};
    vt[8]  = '{1'b1, 1'b0, OP_NOR, 32'h2,        32'h0,        32'h0,        32'h0,        5'd0,  5'd5,  1'b0, 1'b0, 5'b00001, 32'hFFFFFFFF, 32'h2,        5'd0};
    vt[9]  = '{1'b1, 1'b0, OP_ADD, 32'h3,        32'h100,      32'hDEADBEEF, 32'h8,        5'd10, 5'd1,  1'b0, 1'b1, 5'b00100, 32'h108,      32'hB,        5'd10};
    vt[10] = '{1'b1, 1'b0, 4'b0011, 32'h4,       32'h5,        32'h6,        32'h0,        5'd11, 5'd2,  1'b0, 1'b0, 5'b00001, 32'h0,        32'h4,        5'd11};
    vt[11] = '{1'b0, 1'b0, OP_ADD, 32'h7,        32'h1,        32'h1,        32'h1,        5'd1,  5'd1,  1'b0, 1'b0, 5'b11111, 32'h0,        32'h0,        5'd0};
    vt[12] = '{1'b1, 1'b1, OP_ADD, 32'h7,        32'h1,        32'h1,        32'h1,        5'd1,  5'd1,  1'b0, 1'b0, 5'b11111, 32'h0,        32'h0,        5'd0};
    vt[13] = '{1'b1, 1'b0, OP_SUB, 32'h8,        32'h3,        32'h5,        32'hFFFFFFF8, 5'd1,  5'd2,  1'b0, 1'b0, 5'b00001, 32'hFFFFFFFE, 32'h0,        5'd1};

    reset = 1'b1;
    drive(1'b0, 1'b0, OP_AND, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 5'b00000);
    @(negedge clk);
    @(negedge clk);
    check_all_zero(100);
    reset = 1'b0;

    // Single-cycle table
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].valid, vt[i].flush, vt[i].op, vt[i].pc, vt[i].a, vt[i].b, vt[i].imm,
            vt[i].rt, vt[i].rd, vt[i].reg_dst, vt[i].alu_src, vt[i].ctl);
      if (vt[i].valid && !vt[i].flush)
        cycle(mk_res(i, vt[i].e_alu, vt[i].e_baddr, vt[i].b, vt[i].e_wreg, vt[i].ctl), 1'b0);
      else
        cycle(mk_bub(i), 1'b0);
    end

    // MULs back to back, including a signed operand and a zero multiplier
    mul_seq(200, 32'h00010003, 32'h00020005, 32'h000B000F, -1);
    mul_seq(201, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, -1);
    mul_seq(202, 32'h00001234, 32'h00000000, 32'h00000000, -1);

    // Flush at iteration 10, then an OR must complete in one cycle
    mul_seq(203, 32'h00000007, 32'h00000009, 32'h0, 10);
    drive(1'b1, 1'b0, OP_OR, 32'h60, 32'hF0, 32'h0F, 32'h0, 5'd2, 5'd7, 1'b0, 1'b0, 5'b00001);
    cycle(mk_res(204, 32'hFF, 32'h60, 32'h0F, 5'd2, 5'b00001), 1'b0);

    // Reset in the middle of a MUL, then ADD 2+3
    set_mul(32'h00000011, 32'h00000013);
    cycle(mk_bub(300), 1'b1);
    for (int k = 0; k < 5; k++) cycle(mk_bub(300), 1'b1);
    reset = 1'b1;
    #1;
    check_all_zero(301);
    @(negedge clk);
    check_all_zero(302);
    reset = 1'b0;
    drive(1'b1, 1'b0, OP_ADD, 32'h50, 32'h2, 32'h3, 32'h1, 5'd1, 5'd6, 1'b0, 1'b0, 5'b00001);
    cycle(mk_res(303, 32'h5, 32'h51, 32'h3, 5'd1, 5'b00001), 1'b0);

    valid_in = 1'b0;
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
